game_referee: RTL
=================

# game_referee

In-game referee for the typing race: the consumer of the selection/control FSM's `state`, `Mode` and `value` outputs, and the producer of its `finish` input. While the game is running it:
- keeps the clock: time remaining in time mode, elapsed seconds in word mode;
- counts completed words and keystroke errors;
- raises `finish` when the chosen goal is reached;
- drives the four 7-segment digit codes during play and on the score screen.

## Interface
Parameters:
- TICK_CYCLES, 100_000_000: `clk` cycles per game second; the bench uses 10.
- ELAPSED_MAX, 999: saturation value of the elapsed-seconds counter.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  reset; synchronous, active-low.
- state  in  2  control phase: 0 SELECT, 1 COUNTDOWN, 2 INGAME, 3 FINISH.
- Mode  in  1  0 = time mode, 1 = word-count mode.
- value  in  7  target: seconds (15..90) or words (25..100).
- key_valid  in  1  one-cycle pulse, one keystroke decoded.
- key_correct  in  1  qualifies `key_valid`: the keystroke matched the expected character.
- word_done  in  1  one-cycle pulse, a word completed correctly.
- finish  out  1  level, game over; held until `state` returns to SELECT.
- words  out  7  completed words, saturates at 127.
- errors  out  8  wrong keystrokes, saturates at 255.
- nums  out  16  four 4-bit digit/glyph codes; [15:12] is the leftmost digit.

## Operation
Internal FSM, states IDLE, RUN, DONE:
- IDLE:
  - `words`, `errors`, elapsed, and tick counter held at 0.
  - On `state`==INGAME: latch `target`=`value` and `mode_q`=`Mode`, set remaining=`value`, go to RUN.
- RUN:
  - Tick counter counts 0..TICK_CYCLES-1; a second elapses when it wraps.
  - On each second: elapsed += 1, saturating at ELAPSED_MAX. In time mode, remaining -= 1, floor 0.
  - `word_done`: `words` += 1. `key_valid & !key_correct`: `errors` += 1. `key_valid & key_correct` changes nothing.
  - Time mode: go to DONE when remaining becomes 0.
  - Word mode: go to DONE when `words` reaches `target`.
  - `state`==SELECT while in RUN (abort) → IDLE.
- DONE:
  - `finish`=1. Counters frozen; inputs ignored.
  - `state`==SELECT → IDLE and `finish`=0.

Boundary and simultaneous cases:
- `word_done` in the same cycle as the final second in time mode: the word is counted.
- Word mode with `target` reached in the same cycle as a tick: elapsed includes that tick.
- A change of `value` or `Mode` after the latch in IDLE→RUN has no effect until the next game.
- `target`=0 is never produced upstream; if it occurs, go straight to DONE on the first RUN cycle.

`nums` codes, all digits BCD:
- IDLE: {12,12,12,12}, all blank.
- RUN, time mode: {10, BCD(remaining)}.
- RUN, word mode: {11, BCD(target − words)}.
- DONE, time mode: {13, BCD(words)}.
- DONE, word mode: {13, BCD(elapsed)}.

## Timing
- Reset (`rst`=0 at a `clk` edge): FSM IDLE; `finish`=0; `words`=0; `errors`=0; `nums`=16'hCCCC; tick counter, elapsed, remaining, `target` all 0.
- IDLE→RUN: one cycle after `state`==2 is sampled. The tick counter starts at 0 on entry, so the first second is a full TICK_CYCLES.
- Counters update on the edge that samples the pulse (1-cycle latency).
- `finish` and the DONE state are registered together: `finish` rises on the edge after the terminating counter update, i.e. 2 edges after the final `word_done` or tick.
- `nums` is registered. It reflects the counters with 1 cycle of delay relative to them.
- Upstream moves to FINISH on `finish`. The referee ignores FINISH and waits for SELECT.

## Structure
- Shared package `typeracer_pkg`:
  - state codes SELECT/COUNTDOWN/INGAME/FINISH;
  - glyph codes GLYPH_T=10, GLYPH_W=11, GLYPH_BLANK=12, GLYPH_DONE=13.
  - The control FSM imports the same package.
- Sub-module `bin_to_bcd`: 10-bit binary to three BCD digits, combinational, double-dabble. Instantiated once on the mux-selected display value; the output register lives in `game_referee`.

## Test plan
All scenarios use TICK_CYCLES=10.
- Reset mid-RUN (`rst`=0 for one edge): next cycle `finish`=0, `words`=0, `nums`=16'hCCCC, FSM IDLE.
- Time mode, `value`=15, `state`=2, no keys:
  - `nums` reads {10,0,1,5} and then {10,0,1,4} after 10 cycles;
  - `finish` rises 2 edges after the 15th tick (≈152 cycles after entry).
- Word mode, `value`=25, 25 `word_done` pulses with 20-cycle spacing:
  - `finish` rises 2 edges after the 25th pulse;
  - DONE `nums` = {13, BCD(elapsed)} = {13,0,5,0} (50 s).
- Errors: 300 pulses of `key_valid` with `key_correct`=0 → `errors` saturates at 255; `key_correct`=1 pulses leave `errors` unchanged.
- Time mode, `word_done` coincident with the final tick: `words` includes it; DONE `nums` shows the incremented count.
- Abort: `state` 2→0 in RUN → IDLE next cycle, `finish` never asserted. A new game then latches a new `value` of 30 and `nums` shows {10,0,3,0}.

Source files
------------

// File: rtl/typeracer_pkg.sv
// Shared codes for the typing-race control FSM and the in-game referee:
// control phases and the non-numeric 7-segment glyph codes.
package typeracer_pkg;

  localparam logic [1:0] ST_SELECT    = 2'd0;
  localparam logic [1:0] ST_COUNTDOWN = 2'd1;
  localparam logic [1:0] ST_INGAME    = 2'd2;
  localparam logic [1:0] ST_FINISH    = 2'd3;

  localparam logic [3:0] GLYPH_T     = 4'd10;
  localparam logic [3:0] GLYPH_W     = 4'd11;
  localparam logic [3:0] GLYPH_BLANK = 4'd12;
  localparam logic [3:0] GLYPH_DONE  = 4'd13;

  localparam logic [15:0] NUMS_BLANK = {4{GLYPH_BLANK}};

endpackage

// File: rtl/bin_to_bcd.sv
// Combinational 10-bit binary to three BCD digits (double-dabble).
// Inputs above 999 lose the thousands digit; callers stay within 0..999.
module bin_to_bcd (
  input  logic [9:0]  bin,
  output logic [11:0] bcd
);

  logic [21:0] sr;

  always_comb begin
    sr = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (sr[13:10] >= 4'd5) sr[13:10] = sr[13:10] + 4'd3;
      if (sr[17:14] >= 4'd5) sr[17:14] = sr[17:14] + 4'd3;
      if (sr[21:18] >= 4'd5) sr[21:18] = sr[21:18] + 4'd3;
      sr = sr << 1;
    end
    bcd = sr[21:10];
  end

endmodule

// File: rtl/game_referee.sv
// In-game referee: keeps the game clock, counts words and keystroke errors,
// raises finish when the goal is reached and drives the four digit codes.
module game_referee
  import typeracer_pkg::*;
#(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int ELAPSED_MAX = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic        Mode,
  input  logic [6:0]  value,
  input  logic        key_valid,
  input  logic        key_correct,
  input  logic        word_done,
  output logic        finish,
  output logic [6:0]  words,
  output logic [7:0]  errors,
  output logic [15:0] nums
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    fsm;
  logic [TW-1:0] tick_cnt;
  logic [9:0]    elapsed;
  logic [6:0]    remaining;
  logic [6:0]    target;
  logic          mode_q;

  logic          second;
  logic          goal_met;
  logic [6:0]    words_left;
  logic [9:0]    disp_val;
  logic [3:0]    glyph;
  logic          blank;
  logic [11:0]   disp_bcd;
  logic [15:0]   nums_next;

  assign second     = (tick_cnt == TW'(TICK_CYCLES - 1));
  // Goal is judged on registered counters, so finish trails the last update by one edge.
  assign goal_met   = mode_q ? (words >= target) : (remaining == 7'd0);
  assign words_left = (target > words) ? (target - words) : 7'd0;

  always_comb begin
    blank    = 1'b1;
    glyph    = GLYPH_BLANK;
    disp_val = 10'd0;
    case (fsm)
      S_RUN: begin
        blank = 1'b0;
        if (mode_q) begin
          glyph    = GLYPH_W;
          disp_val = {3'd0, words_left};
        end else begin
          glyph    = GLYPH_T;
          disp_val = {3'd0, remaining};
        end
      end
      S_DONE: begin
        blank    = 1'b0;
        glyph    = GLYPH_DONE;
        disp_val = mode_q ? elapsed : {3'd0, words};
      end
      default: ;
    endcase
  end

  bin_to_bcd u_bcd (
    .bin (disp_val),
    .bcd (disp_bcd)
  );

  assign nums_next = blank ? NUMS_BLANK : {glyph, disp_bcd};

  // NOTE: all state is written with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm       <= S_IDLE;
      finish    <= 1'b0;
      words     <= 7'd0;
      errors    <= 8'd0;
      nums      <= NUMS_BLANK;
      tick_cnt  <= '0;
      elapsed   <= 10'd0;
      remaining <= 7'd0;
      target    <= 7'd0;
      mode_q    <= 1'b0;
    end else begin
      nums <= nums_next;
      case (fsm)
        S_IDLE: begin
          finish   <= 1'b0;
          words    <= 7'd0;
          errors   <= 8'd0;
          elapsed  <= 10'd0;
          tick_cnt <= '0;
          if (state == ST_INGAME) begin
            target    <= value;
            mode_q    <= Mode;
            remaining <= value;
            fsm       <= S_RUN;
          end
        end

        S_RUN: begin
          if (state == ST_SELECT) begin
            fsm <= S_IDLE;
          end else if (goal_met) begin
            fsm    <= S_DONE;
            finish <= 1'b1;
          end else begin
            tick_cnt <= second ? '0 : tick_cnt + 1'b1;
            if (second) begin
              if (elapsed < 10'(ELAPSED_MAX)) elapsed <= elapsed + 10'd1;
              if (!mode_q && remaining != 7'd0) remaining <= remaining - 7'd1;
            end
            if (word_done && words != 7'd127) words <= words + 7'd1;
            if (key_valid && !key_correct && errors != 8'd255) errors <= errors + 8'd1;
          end
        end

        S_DONE: begin
          if (state == ST_SELECT) begin
            fsm    <= S_IDLE;
            finish <= 1'b0;
          end
        end

        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
